// File: rtl/brick_collide.sv
// ============================================================================
//  Module   : brick_collide
//  Brief    : Sequential ball-vs-brick-row collision scanner with per-brick
//             bounce codes and alive mask; one brick evaluated per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module brick_collide #(
    parameter int B_X0    = 4,
    parameter int B_Y0    = 40,
    parameter int B_W     = 36,
    parameter int B_H     = 16,
    parameter int B_PITCH = 37
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic        i_new_game,
    input  logic [11:0] i_x1,
    input  logic [11:0] i_x2,
    input  logic [11:0] i_y1,
    input  logic [11:0] i_y2,
    output logic [33:0] hit_block,
    output logic [16:0] o_alive,
    output logic        o_busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_scan = 2'd1;
    localparam logic [1:0] c_st_pub  = 2'd2;
    localparam logic [4:0] c_last    = 5'd16;

    logic [1:0]  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [11:0] x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
    logic [33:0] shadow_q, shadow_d;
    logic [33:0] hit_q, hit_d;
    logic [16:0] alive_q, alive_d;

    logic        w_stb;
    logic        w_scan;
    logic        w_pub;
    logic [11:0] w_bx1, w_bx2, w_by1, w_by2;
    logic [11:0] w_xlo, w_xhi, w_ylo, w_yhi, w_ox, w_oy;
    logic        w_overlap;
    logic [1:0]  w_code;
    logic [16:0] w_kill;

    assign w_stb = i_ani_stb & i_animate;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a new game outranks a strobe, a strobe outranks the scan
    always_comb begin
        state_d = state_q;
        if (i_new_game) begin
            state_d = c_st_idle;
        end else if (w_stb) begin
            state_d = c_st_scan;
        end else begin
            case (state_q)
                c_st_scan: if (idx_q == c_last) state_d = c_st_pub;
                c_st_pub:  state_d = c_st_idle;
                default:   state_d = c_st_idle;
            endcase
        end
    end

    // Output logic
    always_comb begin
        w_scan = (state_q == c_st_scan);
        w_pub  = (state_q == c_st_pub);
        o_busy = w_scan | w_pub;
    end

    // Geometry of the brick currently under evaluation
    assign w_bx1 = 12'(B_X0) + 12'(idx_q) * 12'(B_PITCH);
    assign w_bx2 = w_bx1 + 12'(B_W - 1);
    assign w_by1 = 12'(B_Y0);
    assign w_by2 = 12'(B_Y0 + B_H - 1);

    assign w_overlap = (x1_q <= w_bx2) && (x2_q >= w_bx1) &&
                       (y1_q <= w_by2) && (y2_q >= w_by1);

    assign w_xlo = (x1_q > w_bx1) ? x1_q : w_bx1;
    assign w_xhi = (x2_q < w_bx2) ? x2_q : w_bx2;
    assign w_ylo = (y1_q > w_by1) ? y1_q : w_by1;
    assign w_yhi = (y2_q < w_by2) ? y2_q : w_by2;
    assign w_ox  = w_xhi - w_xlo;
    assign w_oy  = w_yhi - w_ylo;

    always_comb begin
        w_code = 2'b00;
        if (w_overlap && alive_q[idx_q]) begin
            if (w_ox > w_oy)      w_code = 2'b01;
            else if (w_ox < w_oy) w_code = 2'b10;
            else                  w_code = 2'b11;
        end
    end

    generate
        for (genvar k = 0; k < 17; k++) begin : g_kill
            assign w_kill[k] = |shadow_q[2*k +: 2];
        end
    endgenerate

    always_comb begin
        idx_d    = idx_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        y1_d     = y1_q;
        y2_d     = y2_q;
        shadow_d = shadow_q;
        hit_d    = hit_q;
        alive_d  = alive_q;
        if (i_new_game) begin
            alive_d  = '1;
            hit_d    = '0;
            shadow_d = '0;
            idx_d    = '0;
        end else if (w_stb) begin
            x1_d     = i_x1;
            x2_d     = i_x2;
            y1_d     = i_y1;
            y2_d     = i_y2;
            shadow_d = '0;
            hit_d    = '0;
            idx_d    = '0;
        end else if (w_scan) begin
            shadow_d[{idx_q, 1'b0} +: 2] = w_code;
            if (idx_q != c_last) idx_d = idx_q + 5'd1;
        end else if (w_pub) begin
            hit_d   = shadow_q;
            alive_d = alive_q & ~w_kill;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q    <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
            y1_q     <= '0;
            y2_q     <= '0;
            shadow_q <= '0;
            hit_q    <= '0;
            alive_q  <= '1;
        end else begin
            idx_q    <= idx_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            y1_q     <= y1_d;
            y2_q     <= y2_d;
            shadow_q <= shadow_d;
            hit_q    <= hit_d;
            alive_q  <= alive_d;
        end
    end

    assign hit_block = hit_q;
    assign o_alive   = alive_q;

endmodule

`default_nettype wire

// File: tb/tb_brick_collide.sv
// ============================================================================
//  Module   : tb_brick_collide
//  Brief    : Directed, table-driven self-checking bench for brick_collide.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_brick_collide;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, anim, ng;
    logic [11:0] x1, x2, y1, y2;
    logic [33:0] hit;
    logic [16:0] alive;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    brick_collide dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ani_stb  (stb),
        .i_animate  (anim),
        .i_new_game (ng),
        .i_x1       (x1),
        .i_x2       (x2),
        .i_y1       (y1),
        .i_y2       (y2),
        .hit_block  (hit),
        .o_alive    (alive),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          new_game;
        logic [11:0] x1, x2, y1, y2;
        logic [33:0] hit;
        logic [16:0] alive;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_new_game();
        ng = 1'b1;
        tick();
        ng = 1'b0;
        chk("new_game_alive", 64'(alive), 64'h1FFFF);
    endtask

    task automatic pulse_stb(input logic [11:0] a, input logic [11:0] b,
                             input logic [11:0] c, input logic [11:0] d);
        x1 = a; x2 = b; y1 = c; y2 = d;
        stb = 1'b1;
        anim = 1'b1;
        tick();
        stb = 1'b0;
    endtask

    // Full scan: strobe edge, 17 scan edges, then the publish edge
    task automatic run_scan(input vec_t v);
        pulse_stb(v.x1, v.x2, v.y1, v.y2);
        chk("clear_on_strobe", 64'(hit), 64'h0);
        chk("busy_in_scan", 64'(busy), 64'h1);
        repeat (17) tick();
        chk("busy_in_pub", 64'(busy), 64'h1);
        chk("hit_before_pub", 64'(hit), 64'h0);
        tick();
        chk("hit_pub", 64'(hit), 64'(v.hit));
        chk("alive_pub", 64'(alive), 64'(v.alive));
        chk("busy_idle", 64'(busy), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 12'd10,  12'd30,  12'd50, 12'd70,   34'h1,           17'h1FFFE};
        vecs[1] = '{1'b0, 12'd10,  12'd30,  12'd50, 12'd70,   34'h0,           17'h1FFFE};
        vecs[2] = '{1'b0, 12'd630, 12'd650, 12'd42, 12'd54,   34'h2_0000_0000, 17'h0FFFE};
        vecs[3] = '{1'b1, 12'd36,  12'd40,  12'd52, 12'd60,   34'h3,           17'h1FFFE};
        vecs[4] = '{1'b0, 12'd36,  12'd40,  12'd52, 12'd60,   34'h0,           17'h1FFFE};
        vecs[5] = '{1'b1, 12'd10,  12'd30,  12'd0,  12'd10,   34'h0,           17'h1FFFF};
        vecs[6] = '{1'b1, 12'd30,  12'd50,  12'd45, 12'd50,   34'h5,           17'h1FFFC};
        vecs[7] = '{1'b1, 12'd39,  12'd41,  12'd55, 12'd60,   34'hF,           17'h1FFFC};
        vecs[8] = '{1'b1, 12'd0,   12'd700, 12'd0,  12'd39,   34'h0,           17'h1FFFF};
        vecs[9] = '{1'b1, 12'd0,   12'd700, 12'd0,  12'd4095, 34'h1_5555_5555, 17'h00000};

        rst = 1'b1; stb = 1'b0; anim = 1'b0; ng = 1'b0;
        x1 = '0; x2 = '0; y1 = '0; y2 = '0;
        #1;
        chk("reset_hit", 64'(hit), 64'h0);
        chk("reset_alive", 64'(alive), 64'h1FFFF);
        chk("reset_busy", 64'(busy), 64'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Strobe without animate enable must not start a scan
        stb = 1'b1; anim = 1'b0;
        tick();
        stb = 1'b0;
        chk("gated_strobe_busy", 64'(busy), 64'h0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].new_game) do_new_game();
            run_scan(vecs[i]);
            tick();
        end

        // Reset mid-scan while all bricks are dead
        pulse_stb(12'd10, 12'd30, 12'd50, 12'd70);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("midscan_rst_alive", 64'(alive), 64'h1FFFF);
        chk("midscan_rst_hit", 64'(hit), 64'h0);
        chk("midscan_rst_busy", 64'(busy), 64'h0);
        tick();
        rst = 1'b0;
        tick();
        run_scan(vecs[0]);

        // New game beats a simultaneous strobe
        x1 = 12'd10; x2 = 12'd30; y1 = 12'd50; y2 = 12'd70;
        ng = 1'b1; stb = 1'b1; anim = 1'b1;
        tick();
        ng = 1'b0; stb = 1'b0;
        chk("ng_prio_alive", 64'(alive), 64'h1FFFF);
        chk("ng_prio_busy", 64'(busy), 64'h0);
        chk("ng_prio_hit", 64'(hit), 64'h0);
        tick();
        chk("ng_prio_busy2", 64'(busy), 64'h0);

        // Abort: restrobe five edges into the scan
        pulse_stb(12'd10, 12'd30, 12'd50, 12'd70);
        repeat (4) tick();
        pulse_stb(12'd10, 12'd30, 12'd50, 12'd70);
        chk("abort_busy", 64'(busy), 64'h1);
        repeat (13) tick();
        chk("abort_no_pub_hit", 64'(hit), 64'h0);
        chk("abort_no_pub_alive", 64'(alive), 64'h1FFFF);
        chk("abort_busy_late", 64'(busy), 64'h1);
        repeat (4) tick();
        chk("abort_busy_pub", 64'(busy), 64'h1);
        tick();
        chk("abort_pub_hit", 64'(hit), 64'h1);
        chk("abort_pub_alive", 64'(alive), 64'h1FFFE);
        chk("abort_pub_busy", 64'(busy), 64'h0);

        // Restrobe during the publish cycle discards the pending result
        do_new_game();
        pulse_stb(12'd10, 12'd30, 12'd50, 12'd70);
        repeat (17) tick();
        pulse_stb(12'd10, 12'd30, 12'd0, 12'd10);
        chk("pub_abort_hit", 64'(hit), 64'h0);
        chk("pub_abort_alive", 64'(alive), 64'h1FFFF);
        chk("pub_abort_busy", 64'(busy), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
